// File: rtl/add_pipe_pkg.sv
// Shared definitions for the segmented pipelined adder/subtractor:
// mode encodings, stage-count derivation and the full-adder cell.
package add_pipe_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int stages_of(input int width, input int seg);
      return width / seg;
   endfunction

   // Returns {carry_out, sum} of a single-bit full adder.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/add_segment.sv
// Combinational SEG-bit ripple adder built from full-adder cells; also exposes
// the carry into its MSB so the top level can derive signed overflow.
module add_segment
   import add_pipe_pkg::*;
#(
   parameter int SEG = 4
) (
   output logic [SEG-1:0] sum,
   output logic           c_out,
   output logic           c_msb_in,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           c_in
);

   logic [SEG:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = c_in;
      for (int i = 0; i < SEG; i++) begin
         {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
      end
   end

   assign c_out    = carry[SEG];
   assign c_msb_in = carry[SEG-1];

endmodule

// File: rtl/add_pipe_unit.sv
// Pipelined WIDTH-bit adder/subtractor split into SEG-bit carry segments, one
// register stage per segment, with a globally stalled valid/ready handshake.
module add_pipe_unit
   import add_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int STAGES = stages_of(WIDTH, SEG);

   if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_cfg_check
      $fatal(1, "add_pipe_unit: WIDTH must be a positive multiple of SEG");
   end

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Level 0 holds the captured operands; level k+1 holds the result of segment k.
   logic             vld_p [0:STAGES];
   logic             cy_p  [0:STAGES];
   logic [WIDTH-1:0] a_p   [0:STAGES-1];
   logic [WIDTH-1:0] b_p   [0:STAGES-1];
   logic [WIDTH-1:0] res_p [1:STAGES];
   logic             ovf_p;

   logic [SEG-1:0]   seg_sum  [0:STAGES-1];
   logic             seg_cout [0:STAGES-1];
   logic             seg_cmsb [0:STAGES-1];
   logic [WIDTH-1:0] res_nxt  [0:STAGES-1];

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   assign b_eff   = (sub == MODE_SUB) ? ~b : b;
   assign cin_eff = (sub == MODE_ADD) ? c_in : ~c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_segment #(.SEG(SEG)) u_seg (
         .sum      (seg_sum[k]),
         .c_out    (seg_cout[k]),
         .c_msb_in (seg_cmsb[k]),
         .a        (a_p[k][k*SEG +: SEG]),
         .b        (b_p[k][k*SEG +: SEG]),
         .c_in     (cy_p[k])
      );

      // Slices at and above k are still zero in res_p[k], so OR-ing merges cleanly.
      if (k == 0) begin : g_first
         assign res_nxt[k] = WIDTH'(seg_sum[k]);
      end else begin : g_rest
         assign res_nxt[k] = res_p[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k <= STAGES; k++) begin
            vld_p[k] <= 1'b0;
            cy_p[k]  <= 1'b0;
         end
         for (int k = 0; k < STAGES; k++) begin
            a_p[k] <= '0;
            b_p[k] <= '0;
         end
         for (int k = 1; k <= STAGES; k++) begin
            res_p[k] <= '0;
         end
         ovf_p <= 1'b0;
      end else if (advance) begin
         // ---- stage _p0: operand capture ----
         vld_p[0] <= in_valid;
         a_p[0]   <= a;
         b_p[0]   <= b_eff;
         cy_p[0]  <= cin_eff;
         for (int k = 1; k < STAGES; k++) begin
            a_p[k] <= a_p[k-1];
            b_p[k] <= b_p[k-1];
         end
         // ---- segment stages: carry k pairs with operand slice k ----
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k+1] <= vld_p[k];
            cy_p[k+1]  <= seg_cout[k];
            res_p[k+1] <= res_nxt[k];
         end
         ovf_p <= seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
      end
   end

   assign out_valid = vld_p[STAGES];
   assign sum       = res_p[STAGES];
   assign c_out     = cy_p[STAGES];
   assign overflow  = ovf_p;

endmodule

// File: tb/tb_add_pipe_unit.sv
// Self-checking bench for add_pipe_unit (WIDTH=16, SEG=4): directed vectors,
// randomized streams against an arithmetic reference model, stalls and resets.
module tb_add_pipe_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        c_out;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic        sb;
      logic [15:0] es;
      logic        eco;
      logic        eov;
   } dvec_t;

   res_t exp_q[$];

   add_pipe_unit #(.WIDTH(16), .SEG(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic res_t ref_model(input logic [15:0] x, input logic [15:0] y,
                                      input logic ci, input logic sb);
      res_t r;
      int ux, uy, sx, sy, cv, ures, sres;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      cv = ci ? 1 : 0;
      if (!sb) begin
         ures = ux + uy + cv;
         sres = sx + sy + cv;
         r.co = (ures > 65535);
      end else begin
         ures = ux - uy - cv;
         sres = sx - sy - cv;
         r.co = (ux >= uy + cv);
      end
      r.s  = ures[15:0];
      r.ov = (sres > 32767) || (sres < -32768);
      return r;
   endfunction

   task automatic idle();
      in_valid = 1'b0;
      a        = 16'h0000;
      b        = 16'h0000;
      c_in     = 1'b0;
      sub      = 1'b0;
   endtask

   task automatic drive_random();
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      c_in     = 1'($urandom);
      sub      = 1'($urandom);
   endtask

   task automatic test_reset();
      int early;
      reset     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 16'h1111;
      b         = 16'h2222;
      c_in      = 1'b1;
      sub       = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (sum !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h want=0000", sum); end
      total++; if (c_out !== 1'b0) begin bad++; $display("FAIL rst_c_out got=%b want=0", c_out); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      repeat (3) @(posedge clock);
      #1;
      total++; if (out_valid !== 1'b0 || sum !== 16'h0000) begin
         bad++; $display("FAIL rst_hold got=%b/%h want=0/0000", out_valid, sum);
      end
      @(negedge clock);
      idle();
      out_ready = 1'b1;
      reset     = 1'b1;
      early     = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (out_valid !== 1'b0) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL rst_no_accept got=%0d valid cycles want=0", early); end
   endtask

   task automatic test_directed();
      dvec_t dv[9];
      int    lat;
      logic  got;
      dv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      dv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      dv[2] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      dv[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      dv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      dv[5] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      dv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      dv[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      dv[8] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         a        = dv[i].a;
         b        = dv[i].b;
         c_in     = dv[i].ci;
         sub      = dv[i].sb;
         #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
         @(posedge clock); #1;
         idle();
         lat = 0;
         got = 1'b0;
         while (lat < 20 && !got) begin
            @(posedge clock); #1;
            lat++;
            if (out_valid === 1'b1) got = 1'b1;
         end
         total++; if (!got || lat != 4) begin bad++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat); end
         total++; if (sum !== dv[i].es) begin bad++; $display("FAIL dir%0d_sum got=%h want=%h", i, sum, dv[i].es); end
         total++; if (c_out !== dv[i].eco) begin bad++; $display("FAIL dir%0d_c_out got=%b want=%b", i, c_out, dv[i].eco); end
         total++; if (overflow !== dv[i].eov) begin bad++; $display("FAIL dir%0d_overflow got=%b want=%b", i, overflow, dv[i].eov); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_back_to_back();
      int   rcv = 0;
      res_t e;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc < 8) drive_random(); else idle();
         #1;
         if (out_valid === 1'b1) begin
            total++; if (cyc != rcv + 5) begin bad++; $display("FAIL b2b_timing out%0d got=cycle %0d want=%0d", rcv, cyc, rcv + 5); end
            if (exp_q.size() == 0) begin
               total++; bad++; $display("FAIL b2b_extra got=%h want=nothing", sum);
            end else begin
               e = exp_q.pop_front();
               total++; if ({sum, c_out, overflow} !== e) begin
                  bad++; $display("FAIL b2b_result out%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum, c_out, overflow, e.s, e.co, e.ov);
               end
            end
            rcv++;
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, c_in, sub));
         @(posedge clock); #1;
      end
      total++; if (rcv != 8 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_count got=%0d want=8", rcv); end
   endtask

   task automatic test_backpressure();
      int          sent  = 0;
      int          rcv   = 0;
      int          stall = 0;
      logic [17:0] held  = '0;
      logic        stalling;
      res_t        e;
      exp_q.delete();
      for (int cyc = 0; cyc < 80 && !(sent == 12 && exp_q.size() == 0); cyc++) begin
         stalling  = (rcv == 2) && (stall < 5);
         out_ready = !stalling;
         if (sent < 12) drive_random(); else idle();
         #1;
         if (stalling) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               bad++; $display("FAIL bp_stall cycle%0d got in_ready=%b out_valid=%b want 0/1", stall, in_ready, out_valid);
            end
            if (stall == 0) held = {sum, c_out, overflow};
            else begin
               total++; if ({sum, c_out, overflow} !== held) begin
                  bad++; $display("FAIL bp_hold cycle%0d got=%h want=%h", stall, {sum, c_out, overflow}, held);
               end
            end
            stall++;
         end
         if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++; $display("FAIL bp_extra got=%h want=nothing", sum);
            end else begin
               e = exp_q.pop_front();
               total++; if ({sum, c_out, overflow} !== e) begin
                  bad++; $display("FAIL bp_result out%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum, c_out, overflow, e.s, e.co, e.ov);
               end
            end
            rcv++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(a, b, c_in, sub));
            sent++;
         end
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      total++; if (sent != 12 || rcv != 12 || exp_q.size() != 0 || stall != 5) begin
         bad++; $display("FAIL bp_drain got sent=%0d rcv=%0d left=%0d stalls=%0d want 12/12/0/5", sent, rcv, exp_q.size(), stall);
      end
   endtask

   task automatic test_random();
      logic        prev_stall = 1'b0;
      logic [18:0] prev_out   = '0;
      int          rcv        = 0;
      res_t        e;
      exp_q.delete();
      for (int cyc = 0; cyc < 340; cyc++) begin
         if (cyc >= 300 && exp_q.size() == 0 && out_valid !== 1'b1) break;
         if (cyc < 300 && $urandom_range(0, 9) < 7) drive_random(); else idle();
         out_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 9) < 6);
         #1;
         if (prev_stall) begin
            total++; if ({out_valid, sum, c_out, overflow} !== prev_out) begin
               bad++; $display("FAIL rnd_hold cycle%0d got=%h want=%h", cyc, {out_valid, sum, c_out, overflow}, prev_out);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_valid, sum, c_out, overflow};
         if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++; $display("FAIL rnd_extra got=%h want=nothing", sum);
            end else begin
               e = exp_q.pop_front();
               total++; if ({sum, c_out, overflow} !== e) begin
                  bad++; $display("FAIL rnd_result out%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum, c_out, overflow, e.s, e.co, e.ov);
               end
            end
            rcv++;
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, c_in, sub));
         @(posedge clock); #1;
      end
      idle();
      out_ready = 1'b1;
      total++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL rnd_drain got left=%0d out_valid=%b want 0/0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      int   lat;
      logic got;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a        = 16'h1230 + 16'(i);
         b        = 16'h1111;
         c_in     = 1'b0;
         sub      = 1'b0;
         @(posedge clock); #1;
      end
      idle();
      total++; if (out_valid !== 1'b1 || sum !== 16'h2341) begin
         bad++; $display("FAIL mid_pre got=%b/%h want=1/2341", out_valid, sum);
      end
      #2;
      reset = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
      total++; if (sum !== 16'h0000 || c_out !== 1'b0 || overflow !== 1'b0) begin
         bad++; $display("FAIL mid_data got=%h/%b/%b want=0000/0/0", sum, c_out, overflow);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b1;
      a        = 16'h00F0;
      b        = 16'h0F0F;
      @(posedge clock); #1;
      idle();
      lat = 0;
      got = 1'b0;
      while (lat < 20 && !got) begin
         @(posedge clock); #1;
         lat++;
         if (out_valid === 1'b1) got = 1'b1;
      end
      total++; if (!got || lat != 4) begin bad++; $display("FAIL mid_latency got=%0d want=4", lat); end
      total++; if (sum !== 16'h0FFF || c_out !== 1'b0 || overflow !== 1'b0) begin
         bad++; $display("FAIL mid_result got=%h/%b/%b want=0fff/0/0", sum, c_out, overflow);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_pipe_unit.md
# add_pipe_unit

Parametrised, pipelined, segmented adder/subtractor. It generalises the single-bit unit-delay full adder into a WIDTH-bit datapath that is split into SEG-bit carry-propagate segments with one register stage per segment. It adds a subtract mode, signed-overflow detection and a valid/ready handshake with back-pressure. It sits between operand sources and arithmetic consumers in the Chapter 4 datapath examples, and is the registered replacement for chains of unit-delay adders.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, segment width in bits. STAGES = WIDTH/SEG, with STAGES ≥ 1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  the block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 selects add, 1 selects subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry-out for add; for subtract, 1 means no borrow.
- overflow  output  1  two's-complement overflow.

## Operation
- Add: sum = a + b + c_in.
- Subtract: sum = a + ~b + !c_in, which equals a − b − c_in. c_out = 1 means no borrow.
- overflow = (carry into MSB) XOR (carry out of MSB).
- Stage k (k = 0..STAGES−1) computes segment k from:
  - the registered operand slice,
  - the registered carry out of segment k−1. Stage 0 uses the effective carry-in, c_in XOR sub.
- Each stage registers the following and passes them forward:
  - the segment result,
  - the carry,
  - the not-yet-added upper operand slices (b already conditionally inverted),
  - the lower result slices produced so far,
  - a valid bit.
- Advance rule: advance = !out_valid | out_ready. This is a global stall: all stages load when advance = 1 and all stages hold when advance = 0.
- in_ready = advance. This is combinational from out_valid and out_ready.
- Bubbles are not squeezed out. An invalid slot travels through the pipeline like data.
- An input is accepted on a rising edge where in_valid & in_ready.
- When advance = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- sum, c_out and overflow come from the last stage's registers. Nothing combinational feeds them from the inputs.

## Timing
- Reset (reset = 0, asynchronous):
  - every valid bit is cleared, so out_valid = 0;
  - all data registers go to 0, so sum = 0, c_out = 0, overflow = 0;
  - in_ready reads 1 during reset, but no input is accepted while reset = 0.
- Latency: a result accepted at edge N appears with out_valid = 1 after edge N+STAGES−1+1, i.e. STAGES edges later, provided no stall occurs.
- Throughput: one result per cycle while out_ready = 1.
- Back-pressure:
  - when out_valid & !out_ready, the whole pipeline and the output hold steady, and in_ready = 0;
  - sum, c_out and overflow must not change while out_valid = 1 and out_ready = 0.
- Simultaneous output and input: out_valid & out_ready together with in_valid on the same edge gives both a handoff and an accept. No cycle is lost.
- Reset mid-operation: in-flight results are discarded and out_valid drops immediately and asynchronously. The first new result appears STAGES edges after the first accept following reset release.
- Boundary case STAGES = 1: the block is a single registered WIDTH-bit adder with latency 1.
- Carry and operand slices are never held across a stall in a stage other than their own. Stage k's carry always pairs with stage k's operand slice.

## Structure
- Shared package/header add_pipe_pkg:
  - STAGES derivation: localparam STAGES = WIDTH/SEG;
  - elaboration check that WIDTH % SEG == 0; a violation is a fatal elaboration error;
  - mode encodings MODE_ADD = 0 and MODE_SUB = 1.
- Sub-module add_segment: a combinational SEG-bit ripple adder built from full-adder cells.
  - Ports: sum[SEG], c_out, c_msb_in (carry into the segment MSB, used for overflow), a[SEG], b[SEG], c_in.
  - The top level instantiates STAGES copies in a generate loop.
  - Only the last segment's c_msb_in is used.

## Test plan
Default configuration for all scenarios: WIDTH = 16, SEG = 4, out_ready = 1 unless stated otherwise.
- Add wrap: a = 0xFFFF, b = 0x0001, c_in = 0, sub = 0 → after 4 edges, sum = 0x0000, c_out = 1, overflow = 0.
- Signed overflow and cross-segment carry chain: a = 0x7FFF, b = 0x0001 → sum = 0x8000, c_out = 0, overflow = 1. Separately, a = 0x0FFF, b = 0x0001 → sum = 0x1000, exercising carry through three segment registers.
- Subtract:
  - a = 0x0005, b = 0x0007, c_in = 0, sub = 1 → sum = 0xFFFE, c_out = 0, overflow = 0;
  - a = 0x8000, b = 0x0001, c_in = 0, sub = 1 → sum = 0x7FFF, overflow = 1;
  - a = 0x0005, b = 0x0002, c_in = 1, sub = 1 → sum = 0x0002, c_out = 1.
- Back-to-back stream: 8 consecutive accepts from the random-vector scoreboard give 8 consecutive out_valid cycles, in order, starting at edge 4.
- Back-pressure:
  - hold out_ready = 0 for 5 cycles with the pipeline full → in_ready = 0 and sum stays stable throughout;
  - on release, results drain in order with no loss or duplication.
- Reset mid-flight: assert reset with 3 operations in flight → out_valid = 0 and sum = 0 immediately; after release, one new add gives out_valid exactly 4 edges after its accept.
